// File: rtl/jstk_pkg.sv
// Shared constants and frame layout for the PmodJSTK responder.
// The byte order matches the joystick reader's DOUT layout.
package jstk_pkg;

   localparam int unsigned JSTK_FRAME_BITS = 40;
   localparam int unsigned JSTK_BYTES      = 5;

   localparam logic [5:0] LED_CMD_DEFAULT = 6'b100000;

   // Bit positions inside the 40-bit frame, byte0 (X low) is sent first
   localparam int unsigned XLO_MSB = 39;
   localparam int unsigned XLO_LSB = 32;
   localparam int unsigned XHI_MSB = 25;
   localparam int unsigned XHI_LSB = 24;
   localparam int unsigned YLO_MSB = 23;
   localparam int unsigned YLO_LSB = 16;
   localparam int unsigned YHI_MSB = 9;
   localparam int unsigned YHI_LSB = 8;
   localparam int unsigned BTN_MSB = 2;
   localparam int unsigned BTN_LSB = 0;

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StDone
   } jstk_state_e;

   function automatic logic [JSTK_FRAME_BITS-1:0] jstk_frame(input logic [9:0] x,
                                                              input logic [9:0] y,
                                                              input logic [2:0] b);
      logic [JSTK_FRAME_BITS-1:0] f;
      f = '0;
      f[XLO_MSB:XLO_LSB] = x[7:0];
      f[XHI_MSB:XHI_LSB] = x[9:8];
      f[YLO_MSB:YLO_LSB] = y[7:0];
      f[YHI_MSB:YHI_LSB] = y[9:8];
      f[BTN_MSB:BTN_LSB] = b;
      return f;
   endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous input, with single-clk
// rise/fall pulses derived from the last stage and one extra delay flop.
module sync_edge #(
   parameter int unsigned STAGES    = 2,
   parameter logic        RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q;
   logic              dly_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= {STAGES{RESET_VAL}};
         dly_q  <= RESET_VAL;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d};
         dly_q  <= sync_q[STAGES-1];
      end
   end

   assign q    = sync_q[STAGES-1];
   assign rise = sync_q[STAGES-1] & ~dly_q;
   assign fall = ~sync_q[STAGES-1] & dly_q;

endmodule

// File: rtl/jstk_spi_responder.sv
// SPI mode-0 slave emulating a PmodJSTK: returns a 5-byte X/Y/button frame
// per SS-framed transaction and decodes the master's LED command byte.
module jstk_spi_responder
   import jstk_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [5:0]  LED_CMD     = LED_CMD_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       SCLK,
   input  logic       SS,
   input  logic       MOSI,
   output logic       MISO,
   input  logic [9:0] joy_x,
   input  logic [9:0] joy_y,
   input  logic [2:0] btn,
   output logic [1:0] led,
   output logic       busy,
   output logic       frame_done
);

   localparam logic [5:0] CNT_FULL = 6'(JSTK_FRAME_BITS);
   localparam logic [5:0] CNT_SAT  = 6'(JSTK_FRAME_BITS + 1);
   localparam logic [5:0] CNT_CMD  = 6'd8;

   logic sclk_s, sclk_rise, sclk_fall;
   logic ss_s, ss_rise, ss_fall;
   logic mosi_s, mosi_rise, mosi_fall;

   sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
      .clk  (clk),
      .rst  (rst),
      .d    (SCLK),
      .q    (sclk_s),
      .rise (sclk_rise),
      .fall (sclk_fall)
   );

   sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
      .clk  (clk),
      .rst  (rst),
      .d    (SS),
      .q    (ss_s),
      .rise (ss_rise),
      .fall (ss_fall)
   );

   sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
      .clk  (clk),
      .rst  (rst),
      .d    (MOSI),
      .q    (mosi_s),
      .rise (mosi_rise),
      .fall (mosi_fall)
   );

   logic unused_sync;
   assign unused_sync = ^{sclk_s, ss_s, mosi_rise, mosi_fall};

   jstk_state_e                 state_q;
   logic [JSTK_FRAME_BITS-1:0]  tx_q;
   logic [7:0]                  rx_q;
   logic [7:0]                  cmd_q;
   logic [5:0]                  cnt_q;
   logic                        miso_q;
   logic [1:0]                  led_q;
   logic                        done_q;

   logic [JSTK_FRAME_BITS-1:0]  snap;
   logic [7:0]                  rx_next;

   assign snap    = jstk_frame(joy_x, joy_y, btn);
   assign rx_next = {rx_q[6:0], mosi_s};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         tx_q    <= '0;
         rx_q    <= '0;
         cmd_q   <= '0;
         cnt_q   <= '0;
         miso_q  <= 1'b0;
         led_q   <= 2'b00;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               miso_q <= 1'b0;
               if (ss_fall) begin
                  tx_q    <= snap;
                  rx_q    <= '0;
                  cmd_q   <= '0;
                  cnt_q   <= '0;
                  miso_q  <= snap[JSTK_FRAME_BITS-1];
                  state_q <= StShift;
               end
            end
            StShift: begin
               // SS rise takes priority over any SCLK edge in the same clk
               if (ss_rise) begin
                  miso_q <= 1'b0;
                  if (cnt_q == CNT_FULL) begin
                     done_q  <= 1'b1;
                     state_q <= StDone;
                  end else begin
                     state_q <= StIdle;
                  end
               end else begin
                  if (sclk_rise) begin
                     rx_q <= rx_next;
                     if (cnt_q != CNT_SAT) cnt_q <= cnt_q + 6'd1;
                     if (cnt_q == CNT_CMD - 6'd1) cmd_q <= rx_next;
                  end
                  // Zeros shift in behind the frame, so MISO idles low past bit 40
                  if (sclk_fall) begin
                     tx_q   <= {tx_q[JSTK_FRAME_BITS-2:0], 1'b0};
                     miso_q <= tx_q[JSTK_FRAME_BITS-2];
                  end
               end
            end
            StDone: begin
               if (cmd_q[7:2] == LED_CMD) led_q <= cmd_q[1:0];
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign MISO       = miso_q;
   assign led        = led_q;
   assign frame_done = done_q;
   assign busy       = (state_q == StShift);

endmodule
